// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler and its output mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Output-mux select encodings; idle line shares the stop (mark) level
    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_DATA  = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

    localparam logic [2:0] LAST_DATA_BIT = 3'd7;

    // Map a scheduler state onto the line-driver mux select
    function automatic logic [1:0] mux_for_state(input state_t s);
        case (s)
            ST_START:  return MUX_START;
            ST_DATA:   return MUX_DATA;
            ST_PARITY: return MUX_PAR;
            default:   return MUX_STOP;
        endcase
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period prescaler: tick pulses once every PRESCALE cycles while clear is low.
// Latency: tick is combinational from the counter; counter restarts at 0 the cycle after clear.
// Backpressure: none; free-running whenever clear is low.
module baud_tick_gen #(
    parameter int PRESCALE = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(PRESCALE - 1);

    logic [7:0] r_cnt;

    assign tick = (r_cnt == LAST);

    // Count cycles within a bit period, wrapping on the tick
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART transmit scheduler driving an external serializer and line mux.
// Latency: grant/READY/DATA_VALID combinational in IDLE; frame is (10 + PAR_EN) x PRESCALE cycles.
// Backpressure: requesters hold VALID until their single-cycle READY; VALID is ignored while BUSY.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] REQ0_DATA,
    input  logic [7:0] REQ1_DATA,
    input  logic       REQ0_VALID,
    input  logic       REQ1_VALID,
    output logic       REQ0_READY,
    output logic       REQ1_READY,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic       ser_done,
    output logic [7:0] P_DATA,
    output logic       DATA_VALID,
    output logic       ser_en,
    output logic [1:0] mux_sel,
    output logic       PAR_TYP_OUT,
    output logic       BUSY,
    output logic       GNT_ID,
    output logic       ERR
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_bit_cnt;
    logic       r_last;
    logic       r_gnt_id;
    logic       r_par_en;
    logic       r_par_typ;
    logic       r_err;
    logic [7:0] r_pdata;

    logic       w_tick;
    logic       w_grant;
    logic       w_winner;
    logic       w_last_tick;

    // Prescaler is held cleared in IDLE so START always begins a full bit period
    baud_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .CLK   (CLK),
        .RST   (RST),
        .clear (r_state == ST_IDLE),
        .tick  (w_tick)
    );

    // Grant is suppressed while RST is high so a reset cycle never accepts a byte
    assign w_grant     = (r_state == ST_IDLE) && (REQ0_VALID || REQ1_VALID) && !RST;
    assign w_last_tick = (r_state == ST_DATA) && w_tick && (r_bit_cnt == LAST_DATA_BIT);

    assign PAR_TYP_OUT = r_par_typ;
    assign GNT_ID      = r_gnt_id;
    assign ERR         = r_err;

    // Round-robin pick: a lone requester wins, a tie goes to the one not granted last
    always_comb begin
        w_winner = REQ1_VALID;
        if (REQ0_VALID && REQ1_VALID) begin
            w_winner = ~r_last;
        end
    end

    // Next-state decode and per-state outputs
    always_comb begin
        w_next     = r_state;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        DATA_VALID = 1'b0;
        P_DATA     = r_pdata;
        ser_en     = 1'b0;
        mux_sel    = mux_for_state(r_state);
        BUSY       = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_next     = ST_START;
                    REQ0_READY = ~w_winner;
                    REQ1_READY = w_winner;
                    DATA_VALID = 1'b1;
                    P_DATA     = w_winner ? REQ1_DATA : REQ0_DATA;
                end
            end
            ST_START: begin
                if (w_tick) w_next = ST_DATA;
            end
            ST_DATA: begin
                ser_en = w_tick;
                if (w_last_tick) w_next = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_tick) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_tick) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Per-frame configuration captured at grant so mid-frame input changes are ignored
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last    <= 1'b1;
            r_gnt_id  <= 1'b0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_pdata   <= 8'h00;
        end else if (w_grant) begin
            r_last    <= w_winner;
            r_gnt_id  <= w_winner;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_pdata   <= w_winner ? REQ1_DATA : REQ0_DATA;
        end
    end

    // Data-bit counter advances on each DATA tick and is zero outside DATA
    always_ff @(posedge CLK) begin
        if (RST || (r_state != ST_DATA)) begin
            r_bit_cnt <= '0;
        end else if (w_tick) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    // Sticky error: serializer completion must coincide exactly with the last data tick
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if ((w_last_tick && !ser_done) || (ser_done && !w_last_tick)) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched at PRESCALE=4.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// ser_done is either modelled (high on the 8th ser_en of a frame) or forced by the test.
module tb_uart_tx_sched;

    localparam int P = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] REQ0_DATA, REQ1_DATA;
    logic       REQ0_VALID, REQ1_VALID;
    logic       REQ0_READY, REQ1_READY;
    logic       PAR_EN, PAR_TYP, ser_done;
    logic [7:0] P_DATA;
    logic       DATA_VALID, ser_en;
    logic [1:0] mux_sel;
    logic       PAR_TYP_OUT, BUSY, GNT_ID, ERR;

    logic       sd_auto, sd_force;
    logic [3:0] en_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    uart_tx_sched #(.PRESCALE(P)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_DATA(REQ0_DATA), .REQ1_DATA(REQ1_DATA),
        .REQ0_VALID(REQ0_VALID), .REQ1_VALID(REQ1_VALID),
        .REQ0_READY(REQ0_READY), .REQ1_READY(REQ1_READY),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_done(ser_done),
        .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .ser_en(ser_en),
        .mux_sel(mux_sel), .PAR_TYP_OUT(PAR_TYP_OUT), .BUSY(BUSY),
        .GNT_ID(GNT_ID), .ERR(ERR)
    );

    // Serializer model: completes on the 8th shift of the frame
    assign ser_done = sd_auto ? (ser_en && (en_cnt == 4'd7)) : sd_force;

    always @(posedge CLK) begin
        if (RST || DATA_VALID) en_cnt <= 4'd0;
        else if (ser_en)       en_cnt <= en_cnt + 4'd1;
    end

    // Observe one frame from the current point until BUSY drops (bounded)
    task automatic measure_frame(output int busy, output int n00, output int n10,
                                 output int n11, output int n01, output int nen,
                                 output int nrdy);
        busy = 0; n00 = 0; n10 = 0; n11 = 0; n01 = 0; nen = 0; nrdy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (BUSY) begin
                busy++;
                case (mux_sel)
                    2'b00: n00++;
                    2'b10: n10++;
                    2'b11: n11++;
                    default: n01++;
                endcase
                if (ser_en) nen++;
                if (REQ0_READY || REQ1_READY || DATA_VALID) nrdy++;
            end else if (busy > 0) begin
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [9:0] st;
        RST = 1'b1; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        REQ0_DATA = 8'h00; REQ1_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        sd_auto = 1'b1; sd_force = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        st = {BUSY, mux_sel, ser_en, DATA_VALID, REQ0_READY, REQ1_READY, GNT_ID, PAR_TYP_OUT, ERR};
        checks++;
        if (st !== 10'b0_01_0_0_0_0_0_0_0) begin
            errors++; $display("FAIL reset_status: got %b expected %b", st, 10'b0_01_0_0_0_0_0_0_0);
        end
        checks++;
        if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_pdata: got %h expected 00", P_DATA); end
        @(posedge CLK); #1 RST = 1'b0;
    endtask

    task automatic test_frame_no_parity();
        int b, n00, n10, n11, n01, nen, nrdy;
        @(posedge CLK); #1;
        REQ0_DATA = 8'hA5; REQ0_VALID = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        @(negedge CLK);
        checks++;
        if ({REQ0_READY, REQ1_READY, DATA_VALID, BUSY} !== 4'b1010) begin
            errors++; $display("FAIL np_grant_strobes: got %b expected 1010", {REQ0_READY, REQ1_READY, DATA_VALID, BUSY});
        end
        checks++;
        if (P_DATA !== 8'hA5) begin errors++; $display("FAIL np_pdata: got %h expected a5", P_DATA); end
        @(posedge CLK); #1 REQ0_VALID = 1'b0;
        measure_frame(b, n00, n10, n11, n01, nen, nrdy);
        checks++; if (b !== 40)   begin errors++; $display("FAIL np_busy_len: got %0d expected 40", b); end
        checks++; if (n00 !== 4)  begin errors++; $display("FAIL np_start_len: got %0d expected 4", n00); end
        checks++; if (n10 !== 32) begin errors++; $display("FAIL np_data_len: got %0d expected 32", n10); end
        checks++; if (n11 !== 0)  begin errors++; $display("FAIL np_parity_len: got %0d expected 0", n11); end
        checks++; if (n01 !== 4)  begin errors++; $display("FAIL np_stop_len: got %0d expected 4", n01); end
        checks++; if (nen !== 8)  begin errors++; $display("FAIL np_ser_en: got %0d expected 8", nen); end
        checks++; if (nrdy !== 0) begin errors++; $display("FAIL np_ready_busy: got %0d expected 0", nrdy); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL np_err: got %b expected 0", ERR); end
        checks++; if (mux_sel !== 2'b01) begin errors++; $display("FAIL np_idle_mux: got %b expected 01", mux_sel); end
        checks++; if (GNT_ID !== 1'b0) begin errors++; $display("FAIL np_gnt_id: got %b expected 0", GNT_ID); end
    endtask

    task automatic test_parity();
        int b, n00, n10, n11, n01, nen, nrdy;
        @(posedge CLK); #1;
        REQ1_DATA = 8'h3C; REQ1_VALID = 1'b1; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        @(negedge CLK);
        checks++;
        if ({REQ0_READY, REQ1_READY, DATA_VALID} !== 3'b011) begin
            errors++; $display("FAIL par_grant_strobes: got %b expected 011", {REQ0_READY, REQ1_READY, DATA_VALID});
        end
        checks++;
        if (P_DATA !== 8'h3C) begin errors++; $display("FAIL par_pdata: got %h expected 3c", P_DATA); end
        // Config changes mid-frame must not alter this frame
        @(posedge CLK); #1 REQ1_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        measure_frame(b, n00, n10, n11, n01, nen, nrdy);
        checks++; if (b !== 44)   begin errors++; $display("FAIL par_busy_len: got %0d expected 44", b); end
        checks++; if (n11 !== 4)  begin errors++; $display("FAIL par_parity_len: got %0d expected 4", n11); end
        checks++; if (n10 !== 32) begin errors++; $display("FAIL par_data_len: got %0d expected 32", n10); end
        checks++; if (nen !== 8)  begin errors++; $display("FAIL par_ser_en: got %0d expected 8", nen); end
        checks++; if (PAR_TYP_OUT !== 1'b1) begin errors++; $display("FAIL par_typ_out: got %b expected 1", PAR_TYP_OUT); end
        checks++; if (GNT_ID !== 1'b1) begin errors++; $display("FAIL par_gnt_id: got %b expected 1", GNT_ID); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL par_err: got %b expected 0", ERR); end
    endtask

    task automatic test_back_to_back();
        int g_id[4], g_cyc[4];
        logic [7:0] g_dat[4];
        int ng = 0;
        int b, n00, n10, n11, n01, nen, nrdy;
        @(posedge CLK); #1;
        REQ0_DATA = 8'h11; REQ1_DATA = 8'h22; REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; PAR_EN = 1'b0;
        for (int i = 0; i < 400 && ng < 4; i++) begin
            @(negedge CLK);
            if (REQ0_READY || REQ1_READY) begin
                checks++;
                if (REQ0_READY && REQ1_READY) begin errors++; $display("FAIL b2b_double_ready: got 11 expected one-hot"); end
                g_id[ng] = int'(REQ1_READY); g_cyc[ng] = i; g_dat[ng] = P_DATA; ng++;
            end
        end
        @(posedge CLK); #1 REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        checks++; if (ng !== 4) begin errors++; $display("FAIL b2b_grant_count: got %0d expected 4", ng); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (g_id[k] !== (k % 2)) begin errors++; $display("FAIL b2b_order[%0d]: got %0d expected %0d", k, g_id[k], k % 2); end
            checks++;
            if (g_dat[k] !== ((k % 2) ? 8'h22 : 8'h11)) begin
                errors++; $display("FAIL b2b_pdata[%0d]: got %h expected %h", k, g_dat[k], ((k % 2) ? 8'h22 : 8'h11));
            end
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (g_cyc[k] - g_cyc[k-1] !== 41) begin
                errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 41", k, g_cyc[k] - g_cyc[k-1]);
            end
        end
        measure_frame(b, n00, n10, n11, n01, nen, nrdy);
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b expected 0", ERR); end
    endtask

    task automatic test_valid_while_busy();
        int b, n00, n10, n11, n01, nen, nrdy;
        @(posedge CLK); #1 REQ0_DATA = 8'h5A; REQ0_VALID = 1'b1;
        @(negedge CLK);
        checks++; if (REQ0_READY !== 1'b1) begin errors++; $display("FAIL vwb_grant0: got %b expected 1", REQ0_READY); end
        @(posedge CLK); #1 REQ0_VALID = 1'b0;
        repeat (10) @(posedge CLK);
        #1 REQ1_DATA = 8'hC3; REQ1_VALID = 1'b1;
        measure_frame(b, n00, n10, n11, n01, nen, nrdy);
        checks++; if (nrdy !== 0) begin errors++; $display("FAIL vwb_ready_busy: got %0d expected 0", nrdy); end
        checks++;
        if ({BUSY, REQ0_READY, REQ1_READY} !== 3'b001) begin
            errors++; $display("FAIL vwb_idle_grant1: got %b expected 001", {BUSY, REQ0_READY, REQ1_READY});
        end
        checks++; if (P_DATA !== 8'hC3) begin errors++; $display("FAIL vwb_pdata: got %h expected c3", P_DATA); end
        @(posedge CLK); #1 REQ1_VALID = 1'b0;
        measure_frame(b, n00, n10, n11, n01, nen, nrdy);
        checks++; if (b !== 40) begin errors++; $display("FAIL vwb_busy_len: got %0d expected 40", b); end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        int b, n00, n10, n11, n01, nen, nrdy;
        logic [9:0] st;
        @(posedge CLK); #1 REQ0_DATA = 8'h0F; REQ1_DATA = 8'hF0; REQ0_VALID = 1'b1; PAR_TYP = 1'b1;
        @(negedge CLK);
        checks++; if (REQ0_READY !== 1'b1) begin errors++; $display("FAIL rmf_grant0: got %b expected 1", REQ0_READY); end
        @(posedge CLK); #1 REQ0_VALID = 1'b0;
        for (int i = 0; i < 100 && n < 3; i++) begin
            @(negedge CLK);
            if (ser_en) n++;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL rmf_reach_bit3: got %0d expected 3", n); end
        // In DATA bit 3: reset with both requesters pending
        @(posedge CLK); #1 RST = 1'b1; REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        st = {BUSY, mux_sel, ser_en, DATA_VALID, REQ0_READY, REQ1_READY, GNT_ID, PAR_TYP_OUT, ERR};
        checks++;
        if (st !== 10'b0_01_0_0_0_0_0_0_0) begin
            errors++; $display("FAIL rmf_status: got %b expected %b", st, 10'b0_01_0_0_0_0_0_0_0);
        end
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL rmf_pdata: got %h expected 00", P_DATA); end
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        // last-granted was 0 before reset; reset restores 1 so REQ0 wins the tie
        checks++;
        if ({REQ0_READY, REQ1_READY, DATA_VALID} !== 3'b101) begin
            errors++; $display("FAIL rmf_tie_after_reset: got %b expected 101", {REQ0_READY, REQ1_READY, DATA_VALID});
        end
        checks++; if (P_DATA !== 8'h0F) begin errors++; $display("FAIL rmf_regrant_pdata: got %h expected 0f", P_DATA); end
        @(posedge CLK); #1 REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; PAR_TYP = 1'b0;
        measure_frame(b, n00, n10, n11, n01, nen, nrdy);
        checks++; if (b !== 40) begin errors++; $display("FAIL rmf_fresh_frame_len: got %0d expected 40", b); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL rmf_err: got %b expected 0", ERR); end
    endtask

    task automatic test_err();
        int b, n00, n10, n11, n01, nen, nrdy;
        sd_auto = 1'b0; sd_force = 1'b0;
        @(posedge CLK); #1 REQ0_DATA = 8'h81; REQ0_VALID = 1'b1;
        @(negedge CLK);
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL err_before: got %b expected 0", ERR); end
        @(posedge CLK); #1 REQ0_VALID = 1'b0;
        measure_frame(b, n00, n10, n11, n01, nen, nrdy);
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL err_no_done: got %b expected 1", ERR); end
        repeat (5) @(negedge CLK);
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", ERR); end
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", ERR); end
        // Stray completion while idle is a sequencing error
        @(posedge CLK); #1 sd_force = 1'b1;
        @(posedge CLK); #1 sd_force = 1'b0;
        @(negedge CLK);
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL err_stray_done: got %b expected 1", ERR); end
        sd_auto = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_frame_no_parity();
        test_parity();
        test_back_to_back();
        test_valid_while_busy();
        test_reset_mid_frame();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter PRESCALE, default 8, SHALL set the number of CLK cycles per UART bit period; legal range is 2..255.
REQ-002 Port CLK, input, 1, SHALL be the single clock; every register updates on its rising edge.
REQ-003 Port RST, input, 1, SHALL be the reset, synchronous and active-high.
REQ-004 Ports REQ0_DATA and REQ1_DATA, input, 8 each, SHALL carry the requester bytes.
REQ-005 Ports REQ0_VALID and REQ1_VALID, input, 1 each, SHALL be the requester byte-valid signals.
REQ-006 Ports REQ0_READY and REQ1_READY, output, 1 each, SHALL be single-cycle accept pulses.
REQ-007 Ports PAR_EN and PAR_TYP, input, 1 each, SHALL be the parity configuration, sampled at grant.
REQ-008 Port ser_done, input, 1, SHALL be the serializer completion flag.
REQ-009 The datapath outputs SHALL be:
- P_DATA, output, 8: granted byte.
- DATA_VALID, output, 1: serializer load pulse.
- ser_en, output, 1: serializer shift enable.
- mux_sel, output, 2: output-mux select.
- PAR_TYP_OUT, output, 1: latched parity type.
REQ-010 The status outputs SHALL be:
- BUSY, output, 1: high whenever a frame is in progress.
- GNT_ID, output, 1: requester owning the current frame.
- ERR, output, 1: sticky sequencing error.

Function
REQ-011 mux_sel encoding SHALL be 00 start (0), 01 stop/idle (1), 10 ser_data, 11 par_bit.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; BUSY = (state != IDLE).
REQ-013 A bit tick SHALL assert when the prescale counter equals PRESCALE-1.
- The counter clears on entry to START and wraps to 0 on every tick.
- Every state except IDLE lasts exactly PRESCALE cycles per bit.
REQ-014 In IDLE with any REQx_VALID high, the block SHALL in that same cycle:
- grant one requester;
- pulse its REQx_READY and DATA_VALID;
- drive P_DATA with that requester's byte;
- latch PAR_EN, PAR_TYP and GNT_ID;
- enter START on the next cycle.
REQ-015 Arbitration SHALL be round-robin: a sole requester always wins; on simultaneous requests the requester not granted last wins; the last-granted register resets to 1, so REQ0 wins the first tie.
REQ-016 REQx_READY and DATA_VALID SHALL be low in every state other than IDLE; REQx_VALID seen while BUSY is ignored and must be held by the requester.
REQ-017 START SHALL drive mux_sel=00 for one bit period, then go to DATA on the tick.
REQ-018 DATA SHALL drive mux_sel=10 for 8 bit periods and pulse ser_en for one cycle on each tick; a 3-bit counter counts ticks 0..7.
REQ-019 On the DATA tick with count 7, the block SHALL:
- go to PARITY if the latched PAR_EN is 1, else to STOP;
- set ERR if ser_done is low in that cycle.
REQ-020 PARITY SHALL drive mux_sel=11 for one bit period, then go to STOP.
REQ-021 STOP SHALL drive mux_sel=01 for one bit period, then go to IDLE.
REQ-022 Frame length SHALL be (10 + PAR_EN) x PRESCALE cycles of BUSY.
- Back-to-back frames have exactly one IDLE (grant) cycle between them.
REQ-023 ser_done high outside the DATA count-7 tick SHALL set ERR; ERR clears only on RST.
REQ-024 PAR_EN/PAR_TYP changes during a frame SHALL NOT affect that frame.
- PAR_TYP_OUT holds the latched value until the next grant.

Reset
REQ-025 On RST, at any point including mid-frame, the block SHALL set:
- state = IDLE, mux_sel = 01;
- ser_en, DATA_VALID, REQx_READY, BUSY, ERR = 0;
- P_DATA = 0x00, GNT_ID = 0, PAR_TYP_OUT = 0;
- prescale and bit counters = 0;
- last-granted = 1.
REQ-026 A frame interrupted by reset SHALL be discarded and not resumed; the request is not re-accepted until VALID is seen in IDLE after reset.

Structure
REQ-027 The state enum and the mux_sel encodings SHALL reside in shared package uart_pkg, which is also used by the mux.
REQ-028 The bit-tick prescaler SHALL be sub-module baud_tick_gen, with inputs CLK, RST, clear and output tick.

Verification (PRESCALE=4)
REQ-029 REQ0 0xA5, PAR_EN=0 -> READY0 for 1 cycle; mux_sel 00(4 cyc), 10(32 cyc), 01(4 cyc); 8 ser_en pulses; BUSY 40 cycles; ERR=0.
REQ-030 REQ1 0x3C, PAR_EN=1, PAR_TYP=1 -> PARITY period of 4 cycles with mux_sel=11; PAR_TYP_OUT=1; BUSY 44 cycles.
REQ-031 REQ0 and REQ1 valid continuously -> grants alternate 0,1,0,1; grants spaced 41 cycles apart with one IDLE cycle between frames.
REQ-032 REQ1_VALID raised mid-frame of REQ0 -> REQ1_READY stays low until the next IDLE cycle.
REQ-033 RST pulsed at DATA bit 3 -> next cycle IDLE, mux_sel=01, BUSY=0, ser_en=0.
REQ-034 ser_done tied low -> ERR=1 after the count-7 tick and remains 1 until RST.
